// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock period monitor.
//   - mon_state_e : monitor FSM states
//   - DEF_*       : default parameter values for clk_period_mon
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STUCK   = 2'd2
  } mon_state_e;

  localparam int DEF_CNT_WIDTH   = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 65535;

endpackage : clk_mon_pkg

// File: rtl/clk_mon_sync.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// Ports:
//   clk     : sampling clock
//   rst_n   : asynchronous active-low reset, clears every stage
//   async_i : asynchronous input level
//   sync_o  : synchronized level, STAGES cycles behind async_i
module clk_mon_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  // Shift chain; only stage 0 may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule : clk_mon_sync

// File: rtl/clk_period_mon.sv
// Measures the period and high time of an asynchronous signal in clk cycles,
// tracks min/max period since reset or clear, and flags a stuck input.
// Ports:
//   clk, rst_n    : clock and asynchronous active-low reset
//   mon_in        : monitored asynchronous signal
//   clr           : synchronous clear of statistics and FSM state
//   period_o      : last rising-to-rising period
//   high_o        : rising-to-first-falling time within that period
//   period_valid  : one-cycle pulse when period_o/high_o update
//   period_min/max: extremes of valid periods since reset/clr
//   stuck         : high while no rising edge seen for TIMEOUT cycles
module clk_period_mon
  import clk_mon_pkg::*;
#(
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mon_in,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic                 period_valid,
  output logic [CNT_WIDTH-1:0] period_min,
  output logic [CNT_WIDTH-1:0] period_max,
  output logic                 stuck
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONES = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] TO_VAL   = CNT_WIDTH'(TIMEOUT);

  logic                 sync_s;
  logic                 dly_q;
  logic                 rise_q;
  logic                 fall_q;
  logic [CNT_WIDTH-1:0] cnt_inc_s;
  logic                 hit_s;

  mon_state_e           state_q,     state_d;
  logic [CNT_WIDTH-1:0] cnt_q,       cnt_d;
  logic                 fall_seen_q, fall_seen_d;
  logic [CNT_WIDTH-1:0] high_cap_q,  high_cap_d;
  logic [CNT_WIDTH-1:0] period_q,    period_d;
  logic [CNT_WIDTH-1:0] high_q,      high_d;
  logic                 valid_q,     valid_d;
  logic [CNT_WIDTH-1:0] min_q,       min_d;
  logic [CNT_WIDTH-1:0] max_q,       max_d;
  logic                 stuck_q,     stuck_d;

  clk_mon_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (mon_in),
    .sync_o  (sync_s)
  );

  // Edge detector. The flags are registered so every detected edge lands
  // exactly SYNC_STAGES+1 cycles after the mon_in change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      dly_q  <= sync_s;
      rise_q <= sync_s & ~dly_q;
      fall_q <= ~sync_s & dly_q;
    end
  end

  // Saturating increment: the counter parks at TIMEOUT and never wraps.
  assign cnt_inc_s = (cnt_q == TO_VAL) ? cnt_q : (cnt_q + CNT_ONE);
  assign hit_s     = (cnt_inc_s == TO_VAL);

  // Next-state and output logic of the monitor FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fall_seen_d = fall_seen_q;
    high_cap_d  = high_cap_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = 1'b0;
    min_d       = min_q;
    max_d       = max_q;
    stuck_d     = stuck_q;

    if (clr) begin
      // clr wins over any edge detected in the same cycle.
      state_d     = ST_ACQUIRE;
      cnt_d       = CNT_ZERO;
      fall_seen_d = 1'b0;
      high_cap_d  = CNT_ZERO;
      min_d       = CNT_ONES;
      max_d       = CNT_ZERO;
      stuck_d     = 1'b0;
    end else begin
      case (state_q)
        ST_ACQUIRE, ST_STUCK: begin
          if (rise_q) begin
            // First rise after acquire/stuck only starts an interval.
            state_d     = ST_MEASURE;
            cnt_d       = CNT_ONE;
            fall_seen_d = 1'b0;
            stuck_d     = 1'b0;
          end else begin
            cnt_d = cnt_inc_s;
            if (hit_s) begin
              state_d = ST_STUCK;
              stuck_d = 1'b1;
            end else begin
              state_d = state_q;
            end
          end
        end
        ST_MEASURE: begin
          if (rise_q) begin
            // cnt_q equals the number of cycles since the previous rise.
            valid_d     = 1'b1;
            period_d    = cnt_q;
            high_d      = fall_seen_q ? high_cap_q : cnt_q;
            min_d       = (cnt_q < min_q) ? cnt_q : min_q;
            max_d       = (cnt_q > max_q) ? cnt_q : max_q;
            cnt_d       = CNT_ONE;
            fall_seen_d = 1'b0;
          end else begin
            if (fall_q && !fall_seen_q) begin
              fall_seen_d = 1'b1;
              high_cap_d  = cnt_q;
            end else begin
              fall_seen_d = fall_seen_q;
            end
            cnt_d = cnt_inc_s;
            if (hit_s) begin
              state_d = ST_STUCK;
              stuck_d = 1'b1;
            end else begin
              state_d = ST_MEASURE;
            end
          end
        end
        default: begin
          state_d = ST_ACQUIRE;
          cnt_d   = CNT_ZERO;
          stuck_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACQUIRE;
      cnt_q       <= CNT_ZERO;
      fall_seen_q <= 1'b0;
      high_cap_q  <= CNT_ZERO;
      period_q    <= CNT_ZERO;
      high_q      <= CNT_ZERO;
      valid_q     <= 1'b0;
      min_q       <= CNT_ONES;
      max_q       <= CNT_ZERO;
      stuck_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fall_seen_q <= fall_seen_d;
      high_cap_q  <= high_cap_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      min_q       <= min_d;
      max_q       <= max_d;
      stuck_q     <= stuck_d;
    end
  end

  assign period_o     = period_q;
  assign high_o       = high_q;
  assign period_valid = valid_q;
  assign period_min   = min_q;
  assign period_max   = max_q;
  assign stuck        = stuck_q;

endmodule : clk_period_mon
